flag_cond_resolver: RTL and testbench
=====================================

Name: flag_cond_resolver

Overview:
- Consumer side of the NZCV flag registers.
- Holds the architectural NZCV state and tracks flag-setting instructions still in flight between issue and flag write-back.
- Resolves B.cond, CBZ and CBNZ requests from the decode stage through a valid/ready handshake. It stalls a request until the flags it needs are committed or can be bypassed from the write-back port.
- Sits between the decode stage (branch requests, issue pulses) and the flag-producing stage (flag writes, squashes).

Parameters:
CNT_W, 2, width of the in-flight flag-setter counter; maximum in flight is 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
fs_issue  input  1  a flag-setting instruction leaves decode this cycle; it is older than any branch presented in the same cycle
fs_wr  input  1  flag-producing stage commits fs_nzcv this cycle
fs_nzcv  input  4  {N,Z,C,V} write data
fs_kill  input  1  an in-flight flag-setter is squashed without writing
br_valid  input  1  branch request valid
br_ready  output  1  request accepted this cycle
br_cond  input  4  ARM condition code
br_cbz  input  1  CBZ request: flags are ignored, taken if br_zero
br_cbnz  input  1  CBNZ request: taken if !br_zero
br_zero  input  1  branch operand equals zero
res_valid  output  1  resolution valid, one-cycle pulse
res_taken  output  1  resolved direction
nzcv  output  4  architectural flags
pend  output  CNT_W  in-flight flag-setter count
fs_full  output  1  pend == 2^CNT_W-1
err  output  1  sticky protocol error

Behaviour:
- Reset (reset==0, asynchronous):
  - nzcv=0000, pend=0, res_valid=0, res_taken=0, err=0.
  - A stalled request is dropped. The requester keeps br_valid high, and the request is accepted after reset because pend is 0.
- Counter:
  - pend_next = pend + fs_issue - fs_wr - fs_kill, registered.
  - fs_wr and fs_kill asserted together: sets err; treated as fs_wr only.
  - fs_issue while fs_full and no decrement in the same cycle: pend holds, err set.
  - fs_wr or fs_kill while pend==0 and no fs_issue: decrement ignored, err set. fs_wr still updates nzcv.
- Flag register: on fs_wr, nzcv <= fs_nzcv at the clock edge. fs_kill never changes nzcv.
- Effective count: eff = pend + fs_issue - fs_kill, computed combinationally.
- br_ready (combinational):
  - 1 when br_cbz or br_cbnz is set.
  - Otherwise 1 when eff==0, or when eff==1 and fs_wr (bypass).
  - Otherwise 0.
  - br_ready is independent of br_valid.
- Flag source for evaluation: fs_nzcv when fs_wr is asserted this cycle, else the nzcv register.
- br_cbz and br_cbnz both set: sets err; treated as CBZ.
- Condition evaluation (cond[3:1]; cond[0]=1 inverts the result except for 111x):
  - 000 EQ: Z
  - 001 CS: C
  - 010 MI: N
  - 011 VS: V
  - 100 HI: C & !Z
  - 101 GE: N==V
  - 110 GT: !Z & (N==V)
  - 111 AL/NV: always taken
- Result timing:
  - On br_valid && br_ready at edge t, res_valid=1 and res_taken=decision during cycle t+1. Latency is 1 cycle.
  - res_valid is 0 in every cycle not preceded by a handshake.
  - Back-to-back handshakes produce back-to-back pulses.
- Stall: while br_valid && !br_ready, no result is produced and the request inputs must be held stable. Changed inputs are taken as a new request, with no error.
- Counter and flag updates proceed in the same cycle as a handshake. Evaluation uses pre-edge state plus the bypass.

Test Plan:
- Reset, then br_valid with cond=0000 and nzcv=0000 -> br_ready=1; res_valid=1 and res_taken=0 on the next cycle.
- fs_issue for 1 cycle, then EQ request held stalled 3 cycles (br_ready=0, pend=1); fs_wr with fs_nzcv=0100 -> br_ready=1 in the same cycle; res_taken=1 (bypass); nzcv=0100 afterwards.
- Two fs_issue, one fs_kill, one fs_wr with fs_nzcv=1001, then GE request -> pend goes 1,2,1,0; ready only after the write; res_taken=1 (N==V).
- CBNZ with br_zero=0 while pend=2 -> br_ready=1, res_taken=1; pend unaffected.
- Three fs_issue at CNT_W=2 -> fs_full=1; a fourth fs_issue -> pend stays 3, err=1. Assert reset mid-stall -> pend=0, err=0, held request is accepted on the first cycle after reset release.
- Sweep all 16 cond codes against all 16 nzcv values with pend=0 -> res_taken matches the evaluation table in every case.

Source files
------------

// File: rtl/flag_cond_resolver.sv
// NZCV flag holder and branch-condition resolver: tracks in-flight flag setters,
// stalls B.cond until flags are committed or bypassable, resolves CBZ/CBNZ at once.
module flag_cond_resolver #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fs_issue,
    input  logic             fs_wr,
    input  logic [3:0]       fs_nzcv,
    input  logic             fs_kill,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [3:0]       br_cond,
    input  logic             br_cbz,
    input  logic             br_cbnz,
    input  logic             br_zero,
    output logic             res_valid,
    output logic             res_taken,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] pend,
    output logic             fs_full,
    output logic             err
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] pend_q, pend_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic             err_q, err_d;

    logic             kill_eff_s;
    logic             dec_s;
    logic [CNT_W+1:0] eff_s;
    logic             eff_zero_s;
    logic             eff_one_s;
    logic [3:0]       flags_s;
    logic             decision_s;
    logic             handshake_s;
    logic             err_set_s;

    // Evaluate an ARM condition code against {N,Z,C,V}; 111x is always taken.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic base;
        case (cond[3:1])
            3'b000:  base = f[2];
            3'b001:  base = f[1];
            3'b010:  base = f[3];
            3'b011:  base = f[0];
            3'b100:  base = f[1] & ~f[2];
            3'b101:  base = (f[3] == f[0]);
            3'b110:  base = ~f[2] & (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        if (cond[3:1] == 3'b111) begin
            return 1'b1;
        end else begin
            return base ^ cond[0];
        end
    endfunction

    // Readiness, effective in-flight count and branch decision.
    always_comb begin
        kill_eff_s = fs_kill & ~fs_wr;
        dec_s      = fs_wr | kill_eff_s;
        // One extra MSB catches the underflow of a stray kill at pend==0.
        eff_s      = {2'b00, pend_q} + {{(CNT_W+1){1'b0}}, fs_issue}
                   - {{(CNT_W+1){1'b0}}, kill_eff_s};
        eff_zero_s = (eff_s == '0) || eff_s[CNT_W+1];
        eff_one_s  = (eff_s == {{(CNT_W+1){1'b0}}, 1'b1});
        flags_s    = fs_wr ? fs_nzcv : nzcv_q;
        if (br_cbz || br_cbnz) begin
            br_ready = 1'b1;
        end else if (eff_zero_s || (eff_one_s && fs_wr)) begin
            br_ready = 1'b1;
        end else begin
            br_ready = 1'b0;
        end
        if (br_cbz) begin
            decision_s = br_zero;
        end else if (br_cbnz) begin
            decision_s = ~br_zero;
        end else begin
            decision_s = cond_eval(br_cond, flags_s);
        end
        handshake_s = br_valid & br_ready;
    end

    // Next-state for counter, flags, result pulse and sticky error.
    always_comb begin
        pend_d      = pend_q;
        nzcv_d      = nzcv_q;
        err_set_s   = 1'b0;
        res_valid_d = handshake_s;
        res_taken_d = handshake_s ? decision_s : 1'b0;
        case ({fs_issue, dec_s})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    err_set_s = 1'b1;
                end else begin
                    pend_d = pend_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (pend_q == '0) begin
                    err_set_s = 1'b1;
                end else begin
                    pend_d = pend_q - CNT_W'(1);
                end
            end
            default: pend_d = pend_q;
        endcase
        if (fs_wr) begin
            nzcv_d = fs_nzcv;
        end else begin
            nzcv_d = nzcv_q;
        end
        if ((fs_wr && fs_kill) || (br_valid && br_cbz && br_cbnz)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = err_set_s;
        end
        err_d = err_q | err_set_s;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q      <= '0;
            nzcv_q      <= 4'b0000;
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            nzcv_q      <= nzcv_d;
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
            err_q       <= err_d;
        end
    end

    assign pend      = pend_q;
    assign nzcv      = nzcv_q;
    assign res_valid = res_valid_q;
    assign res_taken = res_taken_q;
    assign err       = err_q;
    assign fs_full   = (pend_q == PEND_MAX);

endmodule

// File: tb/tb_flag_cond_resolver.sv
// Directed self-checking bench for flag_cond_resolver (CNT_W = 2).
module tb_flag_cond_resolver;

    logic       clk;
    logic       reset;
    logic       fs_issue;
    logic       fs_wr;
    logic [3:0] fs_nzcv;
    logic       fs_kill;
    logic       br_valid;
    logic       br_ready;
    logic [3:0] br_cond;
    logic       br_cbz;
    logic       br_cbnz;
    logic       br_zero;
    logic       res_valid;
    logic       res_taken;
    logic [3:0] nzcv;
    logic [1:0] pend;
    logic       fs_full;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;

    flag_cond_resolver #(.CNT_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .fs_issue (fs_issue),
        .fs_wr    (fs_wr),
        .fs_nzcv  (fs_nzcv),
        .fs_kill  (fs_kill),
        .br_valid (br_valid),
        .br_ready (br_ready),
        .br_cond  (br_cond),
        .br_cbz   (br_cbz),
        .br_cbnz  (br_cbnz),
        .br_zero  (br_zero),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .nzcv     (nzcv),
        .pend     (pend),
        .fs_full  (fs_full),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        fs_issue = 1'b0; fs_wr = 1'b0; fs_nzcv = 4'b0000; fs_kill = 1'b0;
        br_valid = 1'b0; br_cond = 4'b0000; br_cbz = 1'b0; br_cbnz = 1'b0; br_zero = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference condition table written directly from the ARM definitions.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !(cf && !z);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        clr_in();
        reset = 1'b0;
        tick(); tick();
        chk("rst_nzcv", 8'(nzcv), 8'h00);
        chk("rst_pend", 8'(pend), 8'h00);
        chk("rst_resv", 8'(res_valid), 8'h00);
        chk("rst_rest", 8'(res_taken), 8'h00);
        chk("rst_err", 8'(err), 8'h00);
        chk("rst_full", 8'(fs_full), 8'h00);
        reset = 1'b1;
        tick();

        // Plain EQ with zero flags.
        br_valid = 1'b1; br_cond = 4'b0000;
        #1 chk("t1_ready", 8'(br_ready), 8'h01);
        tick();
        chk("t1_resv", 8'(res_valid), 8'h01);
        chk("t1_rest", 8'(res_taken), 8'h00);
        clr_in();
        tick();
        chk("t1_resv_idle", 8'(res_valid), 8'h00);

        // EQ stalled behind one setter, then bypassed from write-back.
        fs_issue = 1'b1;
        tick();
        fs_issue = 1'b0;
        br_valid = 1'b1; br_cond = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_ready", 8'(br_ready), 8'h00);
            chk("t2_stall_pend", 8'(pend), 8'h01);
            tick();
            chk("t2_stall_resv", 8'(res_valid), 8'h00);
        end
        fs_wr = 1'b1; fs_nzcv = 4'b0100;
        #1 chk("t2_bypass_ready", 8'(br_ready), 8'h01);
        tick();
        chk("t2_resv", 8'(res_valid), 8'h01);
        chk("t2_rest", 8'(res_taken), 8'h01);
        chk("t2_nzcv", 8'(nzcv), 8'h04);
        chk("t2_pend", 8'(pend), 8'h00);
        clr_in();
        tick();

        // GE behind two issues, a kill and a write.
        br_valid = 1'b1; br_cond = 4'b1010; fs_issue = 1'b1;
        #1 chk("t3_ready_a", 8'(br_ready), 8'h00);
        tick();
        chk("t3_pend_a", 8'(pend), 8'h01);
        #1 chk("t3_ready_b", 8'(br_ready), 8'h00);
        tick();
        chk("t3_pend_b", 8'(pend), 8'h02);
        fs_issue = 1'b0; fs_kill = 1'b1;
        #1 chk("t3_ready_c", 8'(br_ready), 8'h00);
        tick();
        chk("t3_pend_c", 8'(pend), 8'h01);
        chk("t3_resv_c", 8'(res_valid), 8'h00);
        fs_kill = 1'b0; fs_wr = 1'b1; fs_nzcv = 4'b1001;
        #1 chk("t3_ready_d", 8'(br_ready), 8'h01);
        tick();
        chk("t3_pend_d", 8'(pend), 8'h00);
        chk("t3_resv", 8'(res_valid), 8'h01);
        chk("t3_rest", 8'(res_taken), 8'h01);
        chk("t3_nzcv", 8'(nzcv), 8'h09);
        clr_in();

        // CBNZ ignores pending setters.
        fs_issue = 1'b1;
        tick(); tick();
        fs_issue = 1'b0;
        br_valid = 1'b1; br_cbnz = 1'b1; br_zero = 1'b0; br_cond = 4'b0000;
        #1 chk("t4_ready", 8'(br_ready), 8'h01);
        tick();
        chk("t4_resv", 8'(res_valid), 8'h01);
        chk("t4_rest", 8'(res_taken), 8'h01);
        chk("t4_pend", 8'(pend), 8'h02);
        chk("t4_err", 8'(err), 8'h00);
        clr_in();

        // Saturation, overflow error, reset during stall.
        fs_issue = 1'b1;
        tick();
        chk("t5_pend3", 8'(pend), 8'h03);
        chk("t5_full", 8'(fs_full), 8'h01);
        chk("t5_err0", 8'(err), 8'h00);
        tick();
        chk("t5_pend_hold", 8'(pend), 8'h03);
        chk("t5_err1", 8'(err), 8'h01);
        fs_issue = 1'b0;
        br_valid = 1'b1; br_cond = 4'b1110;
        #1 chk("t5_stall_ready", 8'(br_ready), 8'h00);
        tick();
        chk("t5_stall_resv", 8'(res_valid), 8'h00);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_pend", 8'(pend), 8'h00);
        chk("t5_rst_err", 8'(err), 8'h00);
        tick();
        reset = 1'b1;
        #1 chk("t5_post_ready", 8'(br_ready), 8'h01);
        tick();
        chk("t5_post_resv", 8'(res_valid), 8'h01);
        chk("t5_post_rest", 8'(res_taken), 8'h01);
        clr_in();
        tick();

        // Full condition sweep with back-to-back requests.
        for (int n = 0; n < 16; n++) begin
            fs_wr = 1'b1; fs_nzcv = 4'(n);
            tick();
            fs_wr = 1'b0;
            br_valid = 1'b1;
            for (int c = 0; c < 16; c++) begin
                br_cond = 4'(c);
                tick();
                chk($sformatf("sweep_v_c%0d_n%0d", c, n), 8'(res_valid), 8'h01);
                chk($sformatf("sweep_t_c%0d_n%0d", c, n), 8'(res_taken),
                    8'(ref_cond(4'(c), 4'(n))));
            end
            br_valid = 1'b0;
        end
        clr_in();

        // CBZ+CBNZ together resolves as CBZ and flags an error.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        br_valid = 1'b1; br_cbz = 1'b1; br_cbnz = 1'b1; br_zero = 1'b1;
        tick();
        chk("t7_rest", 8'(res_taken), 8'h01);
        chk("t7_err", 8'(err), 8'h01);
        clr_in();

        // Write and kill together act as a write only.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        fs_issue = 1'b1;
        tick();
        fs_issue = 1'b0; fs_wr = 1'b1; fs_kill = 1'b1; fs_nzcv = 4'b0011;
        tick();
        chk("t8_pend", 8'(pend), 8'h00);
        chk("t8_nzcv", 8'(nzcv), 8'h03);
        chk("t8_err", 8'(err), 8'h01);
        clr_in();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
